bit_edge_counter: RTL and testbench

Per-bit rising-edge event counter for a WIDTH-bit status bus. Each input bit has its own CNT_WIDTH counter with a selectable saturate or wrap policy and a sticky overflow flag. Counters are read through a single-request port with optional read-and-clear. The block sits beside the data path and also passes the input through a registered copy.

---
 rtl/bit_edge_counter.sv | 114 +++++++++++
 tb/tb_bit_edge_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_edge_counter.sv
// Per-bit rising-edge event counters with saturate/wrap policy, sticky overflow flags,
// a one-cycle read port with optional read-and-clear, and a registered copy of the input bus.
module bit_edge_counter #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 8,
   parameter int SATURATE  = 1,
   parameter int SEL_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic [WIDTH-1:0]     data_i,
   output logic [WIDTH-1:0]     data_o,
   input  logic                 clear_i,
   input  logic                 rd_req_i,
   input  logic [SEL_WIDTH-1:0] rd_sel_i,
   input  logic                 rd_clr_i,
   output logic                 rd_valid_o,
   output logic [CNT_WIDTH-1:0] rd_data_o,
   output logic                 rd_ovf_o,
   output logic                 rd_err_o,
   output logic [WIDTH-1:0]     ovf_o
);

   logic [WIDTH-1:0]     r_data_q;
   logic [CNT_WIDTH-1:0] r_cnt [WIDTH];
   logic [WIDTH-1:0]     r_ovf;
   logic                 r_rd_valid;
   logic [CNT_WIDTH-1:0] r_rd_data;
   logic                 r_rd_ovf;
   logic                 r_rd_err;

   logic [WIDTH-1:0]     w_edge;
   logic                 w_sel_ok;
   logic                 w_rd_clr;
   logic [CNT_WIDTH-1:0] w_rd_cnt;
   logic                 w_rd_ovf;

   assign w_edge   = {WIDTH{en_i}} & data_i & ~r_data_q;
   assign w_sel_ok = (32'(rd_sel_i) < WIDTH);
   assign w_rd_clr = rd_req_i & rd_clr_i & w_sel_ok;

   // Select mux walks the valid channels only, so out-of-range selects read as zero.
   always_comb begin
      w_rd_cnt = '0;
      w_rd_ovf = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         if (rd_sel_i == SEL_WIDTH'(k)) begin
            w_rd_cnt = r_cnt[k];
            w_rd_ovf = r_ovf[k];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data_q <= '0;
      end else begin
         r_data_q <= data_i;
      end
   end

   // Priority: global clear, then read-and-clear of the selected channel, then increment.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ovf <= '0;
         for (int k = 0; k < WIDTH; k++) begin
            r_cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < WIDTH; k++) begin
            if (clear_i) begin
               r_cnt[k] <= '0;
               r_ovf[k] <= 1'b0;
            end else if (w_rd_clr && (rd_sel_i == SEL_WIDTH'(k))) begin
               r_cnt[k] <= w_edge[k] ? CNT_WIDTH'(1) : '0;
               r_ovf[k] <= 1'b0;
            end else if (w_edge[k]) begin
               if (&r_cnt[k]) begin
                  r_ovf[k] <= 1'b1;
                  if (SATURATE == 0) begin
                     r_cnt[k] <= '0;
                  end
               end else begin
                  r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
               end
            end
         end
      end
   end

   // Response captures pre-update state, so a read-and-clear never loses the returned count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_rd_ovf   <= 1'b0;
         r_rd_err   <= 1'b0;
      end else begin
         r_rd_valid <= rd_req_i;
         r_rd_data  <= (rd_req_i && w_sel_ok) ? w_rd_cnt : '0;
         r_rd_ovf   <= rd_req_i & w_sel_ok & w_rd_ovf;
         r_rd_err   <= rd_req_i & ~w_sel_ok;
      end
   end

   assign data_o     = r_data_q;
   assign ovf_o      = r_ovf;
   assign rd_valid_o = r_rd_valid;
   assign rd_data_o  = r_rd_data;
   assign rd_ovf_o   = r_rd_ovf;
   assign rd_err_o   = r_rd_err;

endmodule

// File: tb/tb_bit_edge_counter.sv
// Directed bench for bit_edge_counter: four instances (default, 2-bit saturate, 2-bit wrap,
// 6-channel) share one stimulus stream; expected values are hand-computed constants.
module tb_bit_edge_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] data;
   logic       clear;
   logic       rd_req;
   logic [2:0] rd_sel;
   logic       rd_clr;

   logic [7:0] d_data_o, d_rd_data, d_ovf;
   logic       d_rd_valid, d_rd_ovf, d_rd_err;
   logic [7:0] s_data_o, s_ovf;
   logic [1:0] s_rd_data;
   logic       s_rd_valid, s_rd_ovf, s_rd_err;
   logic [7:0] w_data_o, w_ovf;
   logic [1:0] w_rd_data;
   logic       w_rd_valid, w_rd_ovf, w_rd_err;
   logic [5:0] x_data_o, x_ovf;
   logic [7:0] x_rd_data;
   logic       x_rd_valid, x_rd_ovf, x_rd_err;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   bit_edge_counter #(.WIDTH(8), .CNT_WIDTH(8), .SATURATE(1)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .data_i(data), .data_o(d_data_o),
      .clear_i(clear), .rd_req_i(rd_req), .rd_sel_i(rd_sel), .rd_clr_i(rd_clr),
      .rd_valid_o(d_rd_valid), .rd_data_o(d_rd_data), .rd_ovf_o(d_rd_ovf),
      .rd_err_o(d_rd_err), .ovf_o(d_ovf));

   bit_edge_counter #(.WIDTH(8), .CNT_WIDTH(2), .SATURATE(1)) u_sat (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .data_i(data), .data_o(s_data_o),
      .clear_i(clear), .rd_req_i(rd_req), .rd_sel_i(rd_sel), .rd_clr_i(rd_clr),
      .rd_valid_o(s_rd_valid), .rd_data_o(s_rd_data), .rd_ovf_o(s_rd_ovf),
      .rd_err_o(s_rd_err), .ovf_o(s_ovf));

   bit_edge_counter #(.WIDTH(8), .CNT_WIDTH(2), .SATURATE(0)) u_wrp (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .data_i(data), .data_o(w_data_o),
      .clear_i(clear), .rd_req_i(rd_req), .rd_sel_i(rd_sel), .rd_clr_i(rd_clr),
      .rd_valid_o(w_rd_valid), .rd_data_o(w_rd_data), .rd_ovf_o(w_rd_ovf),
      .rd_err_o(w_rd_err), .ovf_o(w_ovf));

   bit_edge_counter #(.WIDTH(6), .CNT_WIDTH(8), .SATURATE(1)) u_w6 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .data_i(data[5:0]), .data_o(x_data_o),
      .clear_i(clear), .rd_req_i(rd_req), .rd_sel_i(rd_sel), .rd_clr_i(rd_clr),
      .rd_valid_o(x_rd_valid), .rd_data_o(x_rd_data), .rd_ovf_o(x_rd_ovf),
      .rd_err_o(x_rd_err), .ovf_o(x_ovf));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [2:0] sel, input logic clr);
      rd_req = 1'b1;
      rd_sel = sel;
      rd_clr = clr;
      step();
      rd_req = 1'b0;
      rd_clr = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; data = 8'hFF; clear = 1'b0;
      rd_req = 1'b0; rd_sel = 3'd0; rd_clr = 1'b0;

      // Reset with data_i held high
      step(); step();
      chk("rst data_o", 32'(d_data_o), 0);
      chk("rst valid", 32'(d_rd_valid), 0);
      chk("rst rd_data", 32'(d_rd_data), 0);
      chk("rst ovf_o", 32'(d_ovf), 0);
      rst_n = 1'b1;
      step();
      chk("pass data_o", 32'(d_data_o), 32'hFF);
      rd(3'd0, 1'b0);
      chk("first edge ch0", 32'(d_rd_data), 1);
      chk("first edge valid", 32'(d_rd_valid), 1);
      rd(3'd7, 1'b0);
      chk("first edge ch7", 32'(d_rd_data), 1);
      chk("err on valid sel", 32'(d_rd_err), 0);
      step();
      chk("idle valid", 32'(d_rd_valid), 0);
      chk("idle rd_data", 32'(d_rd_data), 0);

      // Count five pulses on bit 3
      do_clear();
      data = 8'h00; step();
      for (int i = 0; i < 5; i++) begin
         data = 8'h08; step();
         data = 8'h00; step();
      end
      rd(3'd3, 1'b0);
      chk("ch3 count", 32'(d_rd_data), 5);
      chk("ch3 ovf", 32'(d_rd_ovf), 0);
      rd(3'd2, 1'b0);
      chk("ch2 count", 32'(d_rd_data), 0);

      // Saturate versus wrap with 2-bit counters
      do_clear();
      for (int i = 0; i < 5; i++) begin
         data = 8'h01; step();
         data = 8'h00; step();
      end
      rd(3'd0, 1'b0);
      chk("sat count", 32'(s_rd_data), 3);
      chk("wrap count", 32'(w_rd_data), 1);
      chk("sat rd_ovf", 32'(s_rd_ovf), 1);
      chk("wrap rd_ovf", 32'(w_rd_ovf), 1);
      chk("8b count", 32'(d_rd_data), 5);
      chk("sat ovf_o0", 32'(s_ovf[0]), 1);
      chk("wrap ovf_o0", 32'(w_ovf[0]), 1);
      chk("8b ovf_o", 32'(d_ovf), 0);

      // Read-and-clear coincident with an edge on bit 1
      do_clear();
      for (int i = 0; i < 4; i++) begin
         data = 8'h02; step();
         data = 8'h00; step();
      end
      data = 8'h02;
      rd(3'd1, 1'b1);
      chk("rdclr value", 32'(d_rd_data), 4);
      chk("rdclr sat value", 32'(s_rd_data), 3);
      chk("rdclr sat ovf", 32'(s_rd_ovf), 1);
      data = 8'h00;
      rd(3'd1, 1'b0);
      chk("after rdclr", 32'(d_rd_data), 1);
      chk("after rdclr ovf", 32'(d_rd_ovf), 0);
      chk("after rdclr sat", 32'(s_rd_data), 1);
      chk("after rdclr sat ovf", 32'(s_rd_ovf), 0);
      chk("sat ovf_o1 cleared", 32'(s_ovf[1]), 0);

      // Global clear beats edges and still returns pre-clear value
      do_clear();
      for (int i = 0; i < 7; i++) begin
         data = 8'h01; step();
         data = 8'h00; step();
      end
      chk("sat ovf before clr", 32'(s_ovf[0]), 1);
      data = 8'hFF; clear = 1'b1;
      rd(3'd0, 1'b0);
      clear = 1'b0;
      chk("clr read", 32'(d_rd_data), 7);
      rd(3'd0, 1'b0);
      chk("post clr ch0", 32'(d_rd_data), 0);
      rd(3'd5, 1'b0);
      chk("post clr ch5", 32'(d_rd_data), 0);
      chk("post clr ovf", 32'(s_ovf), 0);

      // Invalid select on the 6-channel instance
      rd(3'd7, 1'b1);
      chk("inv err", 32'(x_rd_err), 1);
      chk("inv valid", 32'(x_rd_valid), 1);
      chk("inv data", 32'(x_rd_data), 0);
      chk("inv ovf", 32'(x_rd_ovf), 0);
      step();
      chk("inv err idle", 32'(x_rd_err), 0);

      // Toggling with en_i low is not counted, nor is raising en_i on a high bit
      en = 1'b0;
      data = 8'h00; step();
      data = 8'hFF; step();
      data = 8'h00; step();
      data = 8'hFF; step();
      en = 1'b1; step();
      rd(3'd3, 1'b0);
      chk("disabled ch3", 32'(d_rd_data), 0);
      chk("disabled data_o", 32'(d_data_o), 32'hFF);
      data = 8'h00; step();
      data = 8'h08; step();
      rd(3'd3, 1'b0);
      chk("reenabled ch3", 32'(d_rd_data), 1);

      // Reset during a pending response
      rd_req = 1'b1; rd_sel = 3'd3;
      step();
      chk("pre rst valid", 32'(d_rd_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("mid rst valid", 32'(d_rd_valid), 0);
      chk("mid rst data_o", 32'(d_data_o), 0);
      rd_req = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
